// File: rtl/range_match_pipeline.sv
// range_match_pipeline: slice-serial A vs LB/UB range compare, MSB slice first, one slice per stage.
// Optional saturating hit counter (cnt_clr/hit_cnt) enabled by defining RANGE_HIT_CNT_EN.
module range_match_pipeline #(
    parameter int DATA_W = 16,
    parameter int CHUNK_W = 4
`ifdef RANGE_HIT_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
`ifdef RANGE_HIT_CNT_EN
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  hit_cnt,
`endif
    input  logic              in_valid,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] lb_in,
    input  logic [DATA_W-1:0] ub_in,
    output logic              out_valid,
    output logic [2:0]        out_code,
    output logic              out_hit
);
    localparam int N = DATA_W / CHUNK_W;

    typedef enum logic [1:0] {EQ, GT, LT} cmp_t;

    // A decided tracker never changes; an undecided one is settled by the current slice.
    function automatic cmp_t upd(input cmp_t t, input logic [CHUNK_W-1:0] x, input logic [CHUNK_W-1:0] y);
        return t != EQ ? t : x > y ? GT : x < y ? LT : EQ;
    endfunction

    function automatic logic [2:0] code_of(input cmp_t x_l, input cmp_t x_u, input cmp_t u_l);
        return (x_l == GT && x_u == LT) ? 3'b111 :
               {u_l == GT && x_u == EQ, x_l == EQ && x_u == EQ && u_l == EQ, u_l == GT && x_l == EQ};
    endfunction

    logic              v    [N];
    logic [DATA_W-1:0] a_r  [N];
    logic [DATA_W-1:0] l_r  [N];
    logic [DATA_W-1:0] u_r  [N];
    cmp_t              al   [N];
    cmp_t              au   [N];
    cmp_t              ul   [N];
    logic              v_s  [N];
    logic [DATA_W-1:0] a_s  [N];
    logic [DATA_W-1:0] l_s  [N];
    logic [DATA_W-1:0] u_s  [N];
    cmp_t              al_s [N];
    cmp_t              au_s [N];
    cmp_t              ul_s [N];
    cmp_t              al_n [N];
    cmp_t              au_n [N];
    cmp_t              ul_n [N];

    // Stage k consumes the top slice of its source; data is kept left-aligned by shifting.
    always_comb begin
        v_s[0] = in_valid;
        a_s[0] = a_in;
        l_s[0] = lb_in;
        u_s[0] = ub_in;
        al_s[0] = EQ;
        au_s[0] = EQ;
        ul_s[0] = EQ;
        for (int k = 1; k < N; k++) begin
            v_s[k] = v[k-1];
            a_s[k] = a_r[k-1];
            l_s[k] = l_r[k-1];
            u_s[k] = u_r[k-1];
            al_s[k] = al[k-1];
            au_s[k] = au[k-1];
            ul_s[k] = ul[k-1];
        end
        for (int k = 0; k < N; k++) begin
            al_n[k] = upd(al_s[k], a_s[k][DATA_W-1 -: CHUNK_W], l_s[k][DATA_W-1 -: CHUNK_W]);
            au_n[k] = upd(au_s[k], a_s[k][DATA_W-1 -: CHUNK_W], u_s[k][DATA_W-1 -: CHUNK_W]);
            ul_n[k] = upd(ul_s[k], u_s[k][DATA_W-1 -: CHUNK_W], l_s[k][DATA_W-1 -: CHUNK_W]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                v[k] <= 1'b0;
                a_r[k] <= '0;
                l_r[k] <= '0;
                u_r[k] <= '0;
                al[k] <= EQ;
                au[k] <= EQ;
                ul[k] <= EQ;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                v[k] <= v_s[k] & ~flush;
                a_r[k] <= a_s[k] << CHUNK_W;
                l_r[k] <= l_s[k] << CHUNK_W;
                u_r[k] <= u_s[k] << CHUNK_W;
                al[k] <= al_n[k];
                au[k] <= au_n[k];
                ul[k] <= ul_n[k];
            end
        end
    end

    assign out_valid = v[N-1];
    assign out_code = v[N-1] ? code_of(al[N-1], au[N-1], ul[N-1]) : 3'b000;
    assign out_hit = v[N-1] && al[N-1] != LT && au[N-1] != GT;

`ifdef RANGE_HIT_CNT_EN
    logic inc;
    assign inc = v_s[N-1] && !flush && al_n[N-1] != LT && au_n[N-1] != GT;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            hit_cnt <= '0;
        else if (cnt_clr)
            hit_cnt <= '0;
        else if (inc && hit_cnt != '1)
            hit_cnt <= hit_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_range_match_pipeline.sv
// tb_range_match_pipeline: table vectors, corner sequences and random traffic against an arithmetic model.
module tb_range_match_pipeline;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic [15:0] a_in = '0;
    logic [15:0] lb_in = '0;
    logic [15:0] ub_in = '0;
    logic out_valid;
    logic [2:0] out_code;
    logic out_hit;
`ifdef RANGE_HIT_CNT_EN
    logic cnt_clr = 1'b0;
    logic [3:0] hit_cnt;
`endif

    always #5 clk = ~clk;

`ifdef RANGE_HIT_CNT_EN
    range_match_pipeline #(.DATA_W(16), .CHUNK_W(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .cnt_clr(cnt_clr), .hit_cnt(hit_cnt),
        .in_valid(in_valid), .a_in(a_in), .lb_in(lb_in), .ub_in(ub_in),
        .out_valid(out_valid), .out_code(out_code), .out_hit(out_hit));
`else
    range_match_pipeline #(.DATA_W(16), .CHUNK_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .a_in(a_in), .lb_in(lb_in), .ub_in(ub_in),
        .out_valid(out_valid), .out_code(out_code), .out_hit(out_hit));
`endif

    typedef struct {
        logic [15:0] a;
        logic [15:0] lb;
        logic [15:0] ub;
        logic [2:0]  code;
        logic        hit;
    } vec_t;

    int tests = 0;
    int fails = 0;
    int nvalid = 0;
    logic       mv [N];
    logic [2:0] mc [N];
    logic       mh [N];
    int mcnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] ref_res(input logic [15:0] a, input logic [15:0] lb, input logic [15:0] ub);
        logic [2:0] c;
        c = (lb < a && a < ub) ? 3'b111 :
            {ub > lb && a == ub, a == ub && ub == lb, ub > lb && a == lb};
        return {c, a >= lb && a <= ub};
    endfunction

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin
            mv[k] = 1'b0;
            mc[k] = '0;
            mh[k] = 1'b0;
        end
        mcnt = 0;
    endtask

    // One clock: update the model with what the DUT sampled, then compare every output.
    task automatic tick();
        logic [3:0] r;
        @(posedge clk);
        if (!rst) begin
            model_clear();
        end else begin
            r = ref_res(a_in, lb_in, ub_in);
            for (int k = N - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                mc[k] = mc[k-1];
                mh[k] = mh[k-1];
            end
            mv[0] = in_valid;
            mc[0] = r[3:1];
            mh[0] = r[0];
            if (flush)
                for (int k = 0; k < N; k++) mv[k] = 1'b0;
`ifdef RANGE_HIT_CNT_EN
            if (cnt_clr) mcnt = 0;
            else if (mv[N-1] && mh[N-1] && mcnt < 15) mcnt++;
`endif
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(mv[N-1]));
        chk("out_code", 32'(out_code), mv[N-1] ? 32'(mc[N-1]) : 32'd0);
        chk("out_hit", 32'(out_hit), 32'(mv[N-1] && mh[N-1]));
`ifdef RANGE_HIT_CNT_EN
        chk("hit_cnt", 32'(hit_cnt), 32'(mcnt));
`endif
        nvalid += int'(out_valid);
    endtask

    task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] lb, input logic [15:0] ub);
        in_valid = v;
        a_in = a;
        lb_in = lb;
        ub_in = ub;
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{16'h1800, 16'h1000, 16'h2000, 3'b111, 1'b1};
        tbl[1] = '{16'h2000, 16'h1000, 16'h2000, 3'b100, 1'b1};
        tbl[2] = '{16'h1000, 16'h1000, 16'h2000, 3'b001, 1'b1};
        tbl[3] = '{16'h1FFF, 16'h2000, 16'h2000, 3'b000, 1'b0};
        tbl[4] = '{16'h0ABC, 16'h0ABC, 16'h0ABC, 3'b010, 1'b1};
        tbl[5] = '{16'h0ABD, 16'h0ABC, 16'h0ABC, 3'b000, 1'b0};
        tbl[6] = '{16'h2800, 16'h3000, 16'h2000, 3'b000, 1'b0};
        tbl[7] = '{16'h1100, 16'h10FF, 16'h1200, 3'b111, 1'b1};
        tbl[8] = '{16'h0000, 16'h0000, 16'hFFFF, 3'b001, 1'b1};
        tbl[9] = '{16'hFFFF, 16'h0000, 16'hFFFF, 3'b100, 1'b1};
        model_clear();

        #1;
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_code", 32'(out_code), 32'd0);
        chk("reset_hit", 32'(out_hit), 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Isolated items: result appears exactly N edges after sampling.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].lb, tbl[i].ub);
            tick();
            drive(1'b0, '0, '0, '0);
            for (int j = 0; j < N - 1; j++) tick();
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("tbl%0d_code", i), 32'(out_code), 32'(tbl[i].code));
            chk($sformatf("tbl%0d_hit", i), 32'(out_hit), 32'(tbl[i].hit));
        end
        tick();

        // Eight back-to-back items.
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].lb, tbl[i].ub);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        for (int j = 0; j < N + 2; j++) tick();
        chk("b2b_count", 32'(nvalid), 32'd8);

        // Flush on the cycle item 3 is presented: items 1-3 lost, 4-8 delivered.
        nvalid = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].lb, tbl[i].ub);
            flush = (i == 2);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        for (int j = 0; j < N + 2; j++) tick();
        chk("flush_count", 32'(nvalid), 32'd5);

        // Asynchronous reset mid-stream.
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, tbl[i].a, tbl[i].lb, tbl[i].ub);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_code", 32'(out_code), 32'd0);
        chk("arst_hit", 32'(out_hit), 32'd0);
        drive(1'b0, '0, '0, '0);
        model_clear();
        tick();
        rst = 1'b1;
        nvalid = 0;
        for (int j = 0; j < N + 2; j++) tick();
        chk("post_rst_stale", 32'(nvalid), 32'd0);

`ifdef RANGE_HIT_CNT_EN
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'h0005, 16'h0000, 16'h000A);
            tick();
        end
        drive(1'b0, '0, '0, '0);
        for (int j = 0; j < N; j++) tick();
        chk("cnt_sat", 32'(hit_cnt), 32'd15);
        drive(1'b1, 16'h0005, 16'h0000, 16'h000A);
        tick();
        drive(1'b0, '0, '0, '0);
        tick();
        tick();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("cnt_clr_wins", 32'(hit_cnt), 32'd0);
        chk("cnt_clr_item", 32'(out_hit), 32'd1);
        tick();
`endif

        // Random traffic, biased towards boundary equalities.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] lb, ub, a;
            lb = 16'($urandom);
            ub = ($urandom_range(0, 3) == 0) ? lb : 16'($urandom);
            case ($urandom_range(0, 4))
                0: a = lb;
                1: a = ub;
                2: a = lb + 16'd1;
                3: a = (lb & 16'hFF00) | 16'($urandom_range(0, 255));
                default: a = 16'($urandom);
            endcase
            drive($urandom_range(0, 3) != 0, a, lb, ub);
            flush = ($urandom_range(0, 15) == 0);
`ifdef RANGE_HIT_CNT_EN
            cnt_clr = ($urandom_range(0, 31) == 0);
`endif
            tick();
        end
        flush = 1'b0;
`ifdef RANGE_HIT_CNT_EN
        cnt_clr = 1'b0;
`endif
        drive(1'b0, '0, '0, '0);
        for (int j = 0; j < N + 1; j++) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
